// File: rtl/etapa_busqueda_pkg.sv
// ============================================================================
// etapa_busqueda_pkg : shared types and constants for the instruction fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package etapa_busqueda_pkg;

    typedef enum logic [0:0] {
        BUSCAR    = 1'b0,
        DESCARTAR = 1'b1
    } estado_t;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] alinear(input logic [31:0] dir);
        return {dir[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/etapa_busqueda_registro_if_id.sv
// ============================================================================
// registro_if_id : IF/ID pipeline register with flush (bubble) and hold
// Revision: 1.0
// ============================================================================
`default_nettype none

module registro_if_id
    import etapa_busqueda_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        detener,
    input  logic        flush,
    input  logic        cargar,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instruccion,
    output logic [31:0] pc_plus4_out,
    output logic        valido_out
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valido_q, valido_d;

    // Flush beats hold; anything not loaded or held becomes a bubble.
    always_comb begin
        instr_d  = NOP;
        pc4_d    = 32'h0000_0000;
        valido_d = 1'b0;
        if (flush) begin
            instr_d  = NOP;
            pc4_d    = 32'h0000_0000;
            valido_d = 1'b0;
        end else if (detener) begin
            instr_d  = instr_q;
            pc4_d    = pc4_q;
            valido_d = valido_q;
        end else if (cargar) begin
            instr_d  = instr_in;
            pc4_d    = pc_plus4_in;
            valido_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q  <= NOP;
            pc4_q    <= 32'h0000_0000;
            valido_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valido_q <= valido_d;
        end
    end

    assign instruccion  = instr_q;
    assign pc_plus4_out = pc4_q;
    assign valido_out   = valido_q;

endmodule

`default_nettype wire

// File: rtl/etapa_busqueda.sv
// ============================================================================
// etapa_busqueda : instruction fetch stage (PC, imem handshake, redirects, IF/ID)
// Revision: 1.0
// ============================================================================
`default_nettype none

module etapa_busqueda
    import etapa_busqueda_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        detener,
    input  logic        salto,
    input  logic [31:0] jump_address,
    input  logic        branch_tomado,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_dato,
    output logic [31:0] instruccion,
    output logic [31:0] pc_plus4_out,
    output logic        valido_out
);

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;

    logic        w_retener;
    logic        w_redirigir;
    logic [31:0] w_destino;
    logic [31:0] w_pc_mas4;
    logic        w_cargar;

    // A taken branch outranks a stall; a jump is ignored while stalled.
    assign w_retener   = detener & ~branch_tomado;
    assign w_redirigir = branch_tomado | (salto & ~detener);
    assign w_destino   = branch_tomado ? alinear(branch_address) : alinear(jump_address);
    assign w_pc_mas4   = pc_q + 32'd4;
    assign w_cargar    = (estado_q == BUSCAR) & imem_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= BUSCAR;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
        end
    end

    // Next state and PC / held-address update
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        case (estado_q)
            BUSCAR: begin
                if (w_redirigir) begin
                    pc_d = w_destino;
                    if (!imem_ready) begin
                        // Old request still in flight: keep presenting it until it drains.
                        estado_d = DESCARTAR;
                        addr_d   = pc_q;
                    end
                end else if (!w_retener && imem_ready) begin
                    pc_d = w_pc_mas4;
                end
            end
            DESCARTAR: begin
                if (w_redirigir) begin
                    pc_d = w_destino;
                end
                if (!w_retener && imem_ready) begin
                    estado_d = BUSCAR;
                end
            end
            default: estado_d = BUSCAR;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req  = ~rst;
        imem_addr = (estado_q == DESCARTAR) ? addr_q : pc_q;
    end

    registro_if_id #(
        .NOP (NOP)
    ) u_registro_if_id (
        .clk          (clk),
        .rst          (rst),
        .detener      (w_retener),
        .flush        (w_redirigir),
        .cargar       (w_cargar),
        .instr_in     (imem_dato),
        .pc_plus4_in  (w_pc_mas4),
        .instruccion  (instruccion),
        .pc_plus4_out (pc_plus4_out),
        .valido_out   (valido_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_etapa_busqueda.sv
// ============================================================================
// tb_etapa_busqueda : scoreboard bench for the instruction fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_etapa_busqueda;

    logic        clk = 1'b0;
    logic        rst;
    logic        detener, salto, branch_tomado, imem_ready;
    logic [31:0] jump_address, branch_address, imem_dato;
    logic        imem_req;
    logic [31:0] imem_addr, instruccion, pc_plus4_out;
    logic        valido_out;

    logic        req2;
    logic [31:0] addr2, instr2, pc4_2;
    logic        val2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    etapa_busqueda dut (
        .clk            (clk),
        .rst            (rst),
        .detener        (detener),
        .salto          (salto),
        .jump_address   (jump_address),
        .branch_tomado  (branch_tomado),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_dato      (imem_dato),
        .instruccion    (instruccion),
        .pc_plus4_out   (pc_plus4_out),
        .valido_out     (valido_out)
    );

    etapa_busqueda #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .detener        (1'b0),
        .salto          (1'b0),
        .jump_address   (32'h0),
        .branch_tomado  (1'b0),
        .branch_address (32'h0),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ready     (1'b1),
        .imem_dato      (32'hCAFE_0001),
        .instruccion    (instr2),
        .pc_plus4_out   (pc4_2),
        .valido_out     (val2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge: drive inputs, check the request, push the IF/ID
    // expectation, then compare it one edge later and return at the next negedge.
    task automatic cyc(input string tag,
                       input logic rdy, input logic [31:0] dato,
                       input logic det, input logic sal, input logic [31:0] jaddr,
                       input logic br,  input logic [31:0] baddr,
                       input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_val);
        exp_t e;
        imem_ready     = rdy;
        imem_dato      = dato;
        detener        = det;
        salto          = sal;
        jump_address   = jaddr;
        branch_tomado  = br;
        branch_address = baddr;
        #1;
        chk({tag, ".req"},  {31'b0, imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_addr, e_addr);
        sb.push_back('{instr: e_instr, pc4: e_pc4, val: e_val});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".instr"}, instruccion,  e.instr);
        chk({tag, ".pc4"},   pc_plus4_out, e.pc4);
        chk({tag, ".val"},   {31'b0, valido_out}, {31'b0, e.val});
        @(negedge clk);
    endtask

    localparam logic [31:0] W_A = 32'h8C01_0000;
    localparam logic [31:0] W_B = 32'h8C02_0004;
    localparam logic [31:0] W_C = 32'h0043_2020;
    localparam logic [31:0] W_D = 32'h1000_0003;
    localparam logic [31:0] W_E = 32'h2021_0001;
    localparam logic [31:0] W_F = 32'h3C01_1234;
    localparam logic [31:0] W_G = 32'hDEAD_BEEF;
    localparam logic [31:0] W_H = 32'h0800_0010;
    localparam logic [31:0] W_I = 32'hAC01_0008;

    initial begin
        rst            = 1'b1;
        detener        = 1'b0;
        salto          = 1'b0;
        branch_tomado  = 1'b0;
        imem_ready     = 1'b0;
        jump_address   = 32'h0;
        branch_address = 32'h0;
        imem_dato      = 32'h0;
        #1;
        chk("rst.req",   {31'b0, imem_req}, 32'd0);
        chk("rst.instr", instruccion, 32'h0);
        chk("rst.pc4",   pc_plus4_out, 32'h0);
        chk("rst.val",   {31'b0, valido_out}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wrap.addr0", addr2, 32'hFFFF_FFFC);

        // Sequential fetch
        cyc("seq0", 1, W_A, 0, 0, 0, 0, 0, 32'h0, W_A, 32'h4, 1);
        chk("wrap.instr", instr2, 32'hCAFE_0001);
        chk("wrap.pc4",   pc4_2,  32'h0);
        chk("wrap.val",   {31'b0, val2}, 32'd1);
        chk("wrap.addr1", addr2,  32'h0);
        cyc("seq1", 1, W_B, 0, 0, 0, 0, 0, 32'h4, W_B, 32'h8, 1);

        // Stall two cycles at pc=8 with data returning: held, then refetched
        cyc("stall0", 1, W_G, 1, 1, 32'h300, 0, 0, 32'h8, W_B, 32'h8, 1);
        cyc("stall1", 0, W_G, 1, 0, 0,       0, 0, 32'h8, W_B, 32'h8, 1);
        cyc("seq2",   1, W_C, 0, 0, 0,       0, 0, 32'h8, W_C, 32'hC, 1);

        // Branch and jump together, also under stall: branch wins
        cyc("brj",   1, W_D, 1, 1, 32'h200, 1, 32'h100, 32'hC, 32'h0, 32'h0, 0);
        cyc("brtgt", 1, W_E, 0, 0, 0, 0, 0, 32'h100, W_E, 32'h104, 1);

        // Jump with data ready: flushed, stays in normal fetch
        cyc("jmp",   1, W_F, 0, 1, 32'h10, 0, 0, 32'h104, 32'h0, 32'h0, 0);
        cyc("wait0", 0, W_G, 0, 0, 0,      0, 0, 32'h10,  32'h0, 32'h0, 0);

        // Redirects while request at 0x10 is outstanding; newest target, low bits cleared
        cyc("drn0",  0, W_G, 0, 1, 32'h80, 0, 0, 32'h10, 32'h0, 32'h0, 0);
        cyc("drn1",  0, W_G, 0, 1, 32'h43, 0, 0, 32'h10, 32'h0, 32'h0, 0);
        cyc("drn2",  1, W_G, 0, 0, 0,      0, 0, 32'h10, 32'h0, 32'h0, 0);
        cyc("drnok", 1, W_H, 0, 0, 0,      0, 0, 32'h40, W_H, 32'h44, 1);
        cyc("seq3",  1, W_I, 0, 0, 0,      0, 0, 32'h44, W_I, 32'h48, 1);

        // Asynchronous reset while a fetch is waiting
        imem_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst.req",   {31'b0, imem_req}, 32'd0);
        chk("arst.instr", instruccion, 32'h0);
        chk("arst.pc4",   pc_plus4_out, 32'h0);
        chk("arst.val",   {31'b0, valido_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("post", 1, W_A, 0, 0, 0, 0, 0, 32'h0, W_A, 32'h4, 1);

        chk("sb.empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/etapa_busqueda.md
ETAPA_BUSQUEDA -- requirements
Module: etapa_busqueda

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP, default 32'h0000_0000 (sll $0,$0,0), bubble instruction written on flush/empty.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 detener  in  1  stall request from hazard unit; hold PC and IF/ID.
REQ-006 salto  in  1  jump taken, resolved in ID.
REQ-007 jump_address  in  32  jump target from ID.
REQ-008 branch_tomado  in  1  branch taken, resolved in EX.
REQ-009 branch_address  in  32  branch target from EX.
REQ-010 imem_req  out  1  instruction-memory request, held high until imem_ready.
REQ-011 imem_addr  out  32  fetch address, stable while imem_req high and imem_ready low.
REQ-012 imem_ready  in  1  memory returns imem_dato this cycle.
REQ-013 imem_dato  in  32  fetched instruction word.
REQ-014 instruccion  out  32  IF/ID registered instruction, feeds decode stage.
REQ-015 pc_plus4_out  out  32  IF/ID registered address-of-instruction + 4.
REQ-016 valido_out  out  1  IF/ID entry holds a real instruction (0 = bubble).

Function
REQ-017 FSM states BUSCAR (normal fetch) and DESCARTAR (drain one outstanding request whose data is discarded).
REQ-018 BUSCAR: imem_req=1, imem_addr=pc.
REQ-019 BUSCAR, imem_ready=1, no redirect, detener=0: IF/ID <= {imem_dato, pc+4, 1}; pc <= pc+4.
REQ-020 BUSCAR, imem_ready=0, no redirect, detener=0: IF/ID <= {NOP, 0, 0}; pc held.
REQ-021 detener=1, no branch_tomado: pc, IF/ID, state held; returned imem_dato dropped and re-fetched later; salto ignored.
REQ-022 Redirect priority: branch_tomado > salto > sequential; branch_tomado overrides detener.
REQ-023 Redirect: pc <= target with bits [1:0] forced 0; IF/ID <= {NOP, 0, 0} (flush), same edge.
REQ-024 Redirect in BUSCAR with imem_ready=1: stay BUSCAR; fetch at target next cycle.
REQ-025 Redirect in BUSCAR with imem_ready=0: go DESCARTAR; imem_addr keeps old address in an address register.
REQ-026 DESCARTAR: imem_req=1 at held address; on imem_ready data dropped, return to BUSCAR; IF/ID stays bubble.
REQ-027 Redirect while in DESCARTAR: pc <= newest target; remain DESCARTAR until imem_ready.
REQ-028 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-029 Best-case throughput one instruction per cycle; IF/ID latency one edge after imem_ready.

Reset
REQ-030 While rst=1: pc=RESET_PC, state=BUSCAR, imem_req=0, instruccion=NOP, pc_plus4_out=0, valido_out=0.
REQ-031 Reset mid-request abandons outstanding fetch; first cycle after release asserts imem_req at RESET_PC.

Structure
REQ-032 Shared package holds FSM state encoding, NOP constant and RESET_PC default.
REQ-033 One sub-module registro_if_id: IF/ID register with hold (detener) and flush inputs.

Verification
REQ-034 Sequential: imem_ready=1 constant, words A,B,C -> IF/ID shows A/4, B/8, C/12, valido=1, one per cycle.
REQ-035 Stall: detener=1 two cycles at pc=8 -> IF/ID and pc frozen; resume fetches addr 8 next.
REQ-036 Branch vs jump same cycle: branch_tomado=1 (0x100), salto=1 (0x200) -> pc=0x100, IF/ID flushed, valido=0.
REQ-037 Redirect with outstanding fetch: imem_ready=0 at addr 0x10, salto to 0x40 -> imem_addr stays 0x10 until ready, data dropped, next request 0x40.
REQ-038 Wrap and reset: RESET_PC=32'hFFFF_FFFC -> pc_plus4_out=0; assert rst mid-wait -> all outputs per REQ-030 immediately, no clock edge.
